// File: rtl/uart_phy_if.sv
// Mailbox-side handshake bundle of uart_phy: TX byte offer and RX byte/error strobes.
// The mailbox uses the master modport, the PHY the slave modport.
interface uart_phy_if;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ferr;

    modport master (
        output tx_en, tx_data,
        input  tx_ready, tx_busy, rx_data, rx_ready, rx_ferr
    );

    modport slave (
        input  tx_en, tx_data,
        output tx_ready, tx_busy, rx_data, rx_ready, rx_ferr
    );
endinterface

// File: rtl/uart_phy.sv
// 8N1 UART transceiver with a one-byte TX holding register and an independent RX deserialiser.
// Optional build macro UART_PHY_MAJORITY_EN: 3-sample majority vote per RX bit (needs CLKS_PER_BIT >= 6).
module uart_phy #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_phy_if.slave  mbox,
    output logic       txd,
    input  logic       rxd
);
    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAITHI = 3'd4
    } rx_state_t;

    tx_state_t   tx_state_r, tx_state_next_s;
    logic [15:0] tx_cnt_r, tx_cnt_next_s;
    logic [2:0]  tx_bit_r, tx_bit_next_s;
    logic [7:0]  tx_shift_r, tx_shift_next_s;
    logic [7:0]  hold_r;
    logic        tx_ready_r, tx_ready_next_s;
    logic        tx_busy_r, tx_busy_s;
    logic        txd_r, txd_s;
    logic        tx_load_s;
    logic        tx_done_s;

    rx_state_t   rx_state_r, rx_state_next_s;
    logic [15:0] rx_cnt_r, rx_cnt_next_s;
    logic [2:0]  rx_bit_r, rx_bit_next_s;
    logic [7:0]  rx_shift_r, rx_shift_next_s;
    logic [7:0]  rx_data_r;
    logic        rx_ready_r, rx_ready_s;
    logic        rx_ferr_r, rx_ferr_s;
    logic        rx_meta_r, rxs_r;
    logic        rx_done_s;
    logic        rx_smp_s, rx_bit_s, rx_is_stop_s;

    assign tx_done_s = (tx_cnt_r == CNT_LAST);
    assign rx_done_s = (rx_cnt_r == CNT_LAST);

    // TX next state; a load moves the holding byte into the shifter on entry to START
    always_comb begin
        tx_state_next_s = tx_state_r;
        tx_load_s       = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_ready_r) begin
                    tx_state_next_s = TX_START;
                    tx_load_s       = 1'b1;
                end else begin
                    tx_state_next_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_done_s) tx_state_next_s = TX_DATA;
                else           tx_state_next_s = TX_START;
            end
            TX_DATA: begin
                if (tx_done_s && (tx_bit_r == 3'd7)) tx_state_next_s = TX_STOP;
                else                                 tx_state_next_s = TX_DATA;
            end
            TX_STOP: begin
                if (tx_done_s && !tx_ready_r) begin
                    tx_state_next_s = TX_START;
                    tx_load_s       = 1'b1;
                end else if (tx_done_s) begin
                    tx_state_next_s = TX_IDLE;
                end else begin
                    tx_state_next_s = TX_STOP;
                end
            end
            default: tx_state_next_s = TX_IDLE;
        endcase
    end

    // TX datapath next values: bit timer, bit index, shifter, holding-register flag
    always_comb begin
        tx_cnt_next_s   = 16'd0;
        tx_bit_next_s   = tx_bit_r;
        tx_shift_next_s = tx_shift_r;
        tx_ready_next_s = tx_ready_r;
        if (tx_load_s) begin
            tx_shift_next_s = hold_r;
            tx_bit_next_s   = 3'd0;
            tx_ready_next_s = 1'b1;
        end else if (tx_state_r != TX_IDLE) begin
            tx_cnt_next_s = tx_done_s ? 16'd0 : (tx_cnt_r + 16'd1);
            if ((tx_state_r == TX_DATA) && tx_done_s) begin
                tx_shift_next_s = {1'b0, tx_shift_r[7:1]};
                tx_bit_next_s   = tx_bit_r + 3'd1;
            end else begin
                tx_shift_next_s = tx_shift_r;
            end
        end else begin
            tx_cnt_next_s = 16'd0;
        end
        if (!tx_load_s && mbox.tx_en && tx_ready_r) begin
            tx_ready_next_s = 1'b0;
        end else begin
            tx_ready_next_s = tx_ready_next_s;
        end
    end

    // TX outputs decoded from the next state so txd/tx_busy change on the transition edge
    always_comb begin
        txd_s     = 1'b1;
        tx_busy_s = (tx_state_next_s != TX_IDLE);
        case (tx_state_next_s)
            TX_START: txd_s = 1'b0;
            TX_DATA:  txd_s = tx_shift_next_s[0];
            TX_STOP:  txd_s = 1'b1;
            TX_IDLE:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
    end

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_r <= TX_IDLE;
        else        tx_state_r <= tx_state_next_s;
    end

    // TX datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            hold_r     <= 8'h00;
            tx_ready_r <= 1'b1;
            tx_busy_r  <= 1'b0;
            txd_r      <= 1'b1;
        end else begin
            tx_cnt_r   <= tx_cnt_next_s;
            tx_bit_r   <= tx_bit_next_s;
            tx_shift_r <= tx_shift_next_s;
            tx_ready_r <= tx_ready_next_s;
            tx_busy_r  <= tx_busy_s;
            txd_r      <= txd_s;
            if (mbox.tx_en && tx_ready_r) hold_r <= mbox.tx_data;
        end
    end

    // rxd synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rxs_r     <= rx_meta_r;
        end
    end

`ifdef UART_PHY_MAJORITY_EN
    localparam logic [15:0] CNT_PRE = 16'(CLKS_PER_BIT - 2);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic rx_s0_r, rx_s1_r, rx_pend_r, rx_pend_stop_r;

    // Capture the two pre-boundary samples; the vote completes on the following count 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s0_r        <= 1'b0;
            rx_s1_r        <= 1'b0;
            rx_pend_r      <= 1'b0;
            rx_pend_stop_r <= 1'b0;
        end else begin
            if (((rx_state_r == RX_DATA) || (rx_state_r == RX_STOP)) && (rx_cnt_r == CNT_PRE))
                rx_s0_r <= rxs_r;
            rx_pend_r      <= ((rx_state_r == RX_DATA) || (rx_state_r == RX_STOP)) && rx_done_s;
            rx_pend_stop_r <= (rx_state_r == RX_STOP) && rx_done_s;
            if (((rx_state_r == RX_DATA) || (rx_state_r == RX_STOP)) && rx_done_s)
                rx_s1_r <= rxs_r;
        end
    end

    assign rx_smp_s     = rx_pend_r;
    assign rx_bit_s     = maj3(rx_s0_r, rx_s1_r, rxs_r);
    assign rx_is_stop_s = rx_pend_stop_r;
`else
    assign rx_smp_s     = ((rx_state_r == RX_DATA) || (rx_state_r == RX_STOP)) && rx_done_s;
    assign rx_bit_s     = rxs_r;
    assign rx_is_stop_s = (rx_state_r == RX_STOP);
`endif

    // RX next state and bit timer
    always_comb begin
        rx_state_next_s = rx_state_r;
        rx_cnt_next_s   = 16'd0;
        rx_bit_next_s   = rx_bit_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rxs_r) rx_state_next_s = RX_START;
                else        rx_state_next_s = RX_IDLE;
            end
            RX_START: begin
                if (rx_cnt_r == CNT_HALF) rx_state_next_s = rxs_r ? RX_IDLE : RX_DATA;
                else                      rx_cnt_next_s   = rx_cnt_r + 16'd1;
            end
            RX_DATA: begin
                if (rx_done_s) begin
                    rx_bit_next_s = rx_bit_r + 3'd1;
                    if (rx_bit_r == 3'd7) rx_state_next_s = RX_STOP;
                    else                  rx_state_next_s = RX_DATA;
                end else begin
                    rx_cnt_next_s = rx_cnt_r + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_done_s) rx_state_next_s = RX_WAITHI;
                else           rx_cnt_next_s   = rx_cnt_r + 16'd1;
            end
            RX_WAITHI: begin
                if (rxs_r) rx_state_next_s = RX_IDLE;
                else       rx_state_next_s = RX_WAITHI;
            end
            default: rx_state_next_s = RX_IDLE;
        endcase
    end

    // RX outputs: data bits shift in from the top, stop sample decides ready vs framing error
    always_comb begin
        rx_shift_next_s = rx_shift_r;
        rx_ready_s      = rx_smp_s && rx_is_stop_s && rx_bit_s;
        rx_ferr_s       = rx_smp_s && rx_is_stop_s && !rx_bit_s;
        if (rx_smp_s && !rx_is_stop_s) rx_shift_next_s = {rx_bit_s, rx_shift_r[7:1]};
        else                           rx_shift_next_s = rx_shift_r;
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_r <= RX_IDLE;
        else        rx_state_r <= rx_state_next_s;
    end

    // RX datapath and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_ready_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_cnt_r   <= rx_cnt_next_s;
            rx_bit_r   <= rx_bit_next_s;
            rx_shift_r <= rx_shift_next_s;
            rx_ready_r <= rx_ready_s;
            rx_ferr_r  <= rx_ferr_s;
            if (rx_ready_s) rx_data_r <= rx_shift_r;
        end
    end

    assign txd           = txd_r;
    assign mbox.tx_ready = tx_ready_r;
    assign mbox.tx_busy  = tx_busy_r;
    assign mbox.rx_data  = rx_data_r;
    assign mbox.rx_ready = rx_ready_r;
    assign mbox.rx_ferr  = rx_ferr_r;
endmodule

// File: doc/uart_phy.md
# uart_phy

Serial 8N1 UART transceiver on the line side of the UART mailbox interface. Serialises bytes handed over with `tx_en`/`tx_data` onto `txd`, with a one-byte holding register so the mailbox can issue back-to-back bytes. It also deserialises `rxd` into `rx_data` with a single-cycle `rx_ready` strobe. It is the only block that touches the UART pins.

## Interface
- `CLKS_PER_BIT`, 217: clock cycles per bit, minimum 4. Must be less than 2^16.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `tx_en`, input, 1: byte-offer strobe. It is accepted only in a cycle where `tx_ready`=1.
- `tx_data`, input, 8: byte to send. Sampled on the same edge as an accepted `tx_en`.
- `tx_ready`, output, 1: holding register empty. A new byte can be accepted.
- `tx_busy`, output, 1: shifter is currently sending a frame.
- `txd`, output, 1: serial out. Idles high.
- `rxd`, input, 1: serial in. Asynchronous to `clk`.
- `rx_data`, output, 8: last good received byte. Held until the next good byte arrives.
- `rx_ready`, output, 1: one-cycle strobe. `rx_data` is valid in that cycle.
- `rx_ferr`, output, 1: one-cycle strobe. Stop bit was sampled low.

## Operation
- Reset values: `txd`=1, `tx_ready`=1, `tx_busy`=0, `rx_data`=8'h00, `rx_ready`=0, `rx_ferr`=0. All counters and state registers are 0 and the FSMs are IDLE.
- Frame format: start bit 0, then 8 data bits LSB first, then stop bit 1. Every bit lasts exactly `CLKS_PER_BIT` cycles.
- TX holding register:
  - `tx_en` with `tx_ready`=1 loads `tx_data` into the holding register and clears `tx_ready`.
  - `tx_en` with `tx_ready`=0 is ignored. No state changes.
- TX FSM states and transitions:
  - IDLE → START when the holding register is full. On entry the byte moves from holding to the shifter, `tx_ready` returns to 1, and `tx_busy` goes to 1.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits. The bit index is 3 bits and ends at 7.
  - STOP → START directly if the holding register is full, with no idle gap between frames.
  - STOP → IDLE otherwise. `tx_busy` goes to 0 on the same edge.
- TX bit counter: 16-bit counter running 0..`CLKS_PER_BIT`-1, reloading to 0 on each bit boundary.
- RX input path: `rxd` passes through a 2-flop synchroniser. The FSM uses only the synchronised signal `rxs`.
- RX FSM states and transitions:
  - IDLE → START when `rxs`=0.
  - START: at count `CLKS_PER_BIT/2` (integer division), `rxs`=1 is treated as a glitch and returns to IDLE. `rxs`=0 resets the counter and goes to DATA.
  - DATA: each bit is sampled when the counter reaches `CLKS_PER_BIT`-1 and shifted in at bit 7, moving right.
  - STOP: sampled at the same point as data bits.
    - Sample 1: `rx_data` is loaded and `rx_ready` pulses.
    - Sample 0: `rx_ferr` pulses and `rx_data` is unchanged.
    - In both cases go to WAITHI.
  - WAITHI → IDLE once `rxs`=1. This guarantees a line held in break produces exactly one `rx_ferr`.
- TX and RX are fully independent. Simultaneous events on both sides need no arbitration.
- Asserting `rst_n` mid-frame immediately (asynchronously) forces all reset values. A partial byte is discarded and `txd` goes high at once.

## Timing
- TX latency: with TX idle, an accepted `tx_en` at edge E gives `txd`=0 after edge E+1. `tx_ready` is 0 between E and E+1.
- TX throughput: with the holding register refilled before the stop bit ends, frames are exactly 10×`CLKS_PER_BIT` cycles apart.
- RX latency: the falling edge on `rxd` reaches `rxs` after 2 edges. `rx_ready` asserts on the edge about 9.5×`CLKS_PER_BIT`+3 cycles after the `rxd` fall, and lasts exactly 1 cycle.
- `rx_ready` and `rx_ferr` are never high in the same cycle.

## Configuration
- `UART_PHY_MAJORITY_EN` defined:
  - RX data and stop bits are the majority of three samples, taken at counts `CLKS_PER_BIT`-2, `CLKS_PER_BIT`-1 and the next count 0 (edge-aligned around mid-bit).
  - The decision is made at the third sample. `rx_ready`/`rx_ferr` latency grows by 1 cycle.
  - Requires `CLKS_PER_BIT` ≥ 6.
- Not defined: single sample at `CLKS_PER_BIT`-1 as described above.

## Test plan
All scenarios use `CLKS_PER_BIT`=8.
- Reset: hold `rst_n`=0 → `txd`=1, `tx_ready`=1, `rx_ready`=0, `rx_data`=8'h00.
- Single TX: `tx_en` with 8'hA5 → `txd` goes 0 one cycle later, then bits 1,0,1,0,0,1,0,1, then 1, each bit 8 cycles. `tx_busy` is high for exactly 80 cycles.
- Back-to-back TX:
  - Offer 8'h55, then 8'h0F when `tx_ready` rises → the second start bit begins exactly 80 cycles after the first, with no idle.
  - A third `tx_en` while `tx_ready`=0 is dropped.
- RX byte: drive a frame of 8'h3C on `rxd` → one `rx_ready` pulse with `rx_data`=8'h3C. `rx_ferr` stays 0.
- RX framing error and glitch:
  - Frame 8'hFF with stop=0, line then held low for 40 cycles → one `rx_ferr` pulse, no `rx_ready`, `rx_data` unchanged.
  - A 2-cycle low glitch → no strobe.
- Reset mid-frame: assert `rst_n`=0 during TX bit 4 → `txd`=1 immediately. After release, a new `tx_en` sends a complete frame.
